// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth multiplier:
//   state_t        - control FSM states (IDLE, CALC, DONE)
//   sel_t          - recoded partial-product select (ZERO, PM, P2M, NM, N2M)
//   booth_iters()  - number of radix-4 iterations for a given operand width
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } sel_t;

    // Both operands are extended by two bits, so WIDTH+2 multiplier bits are
    // retired two at a time. The mode does not change the count.
    function automatic int booth_iters(input int width);
        return (width / 2) + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// ---------------------------------------------------------------------------
// booth_r4_recoder
// Combinational radix-4 Booth recoder.
//   window : {Q[1], Q[0], Q[-1]} of the current multiplier position
//   sel    : partial-product select (0, +M, +2M, -M, -2M)
// ---------------------------------------------------------------------------
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output sel_t       sel
);

    // Map the overlapping 3-bit window to its signed digit in {-2..+2}
    always_comb begin
        sel = ZERO;
        case (window)
            3'b000:  sel = ZERO;
            3'b001:  sel = PM;
            3'b010:  sel = PM;
            3'b011:  sel = P2M;
            3'b100:  sel = N2M;
            3'b101:  sel = NM;
            3'b110:  sel = NM;
            3'b111:  sel = ZERO;
            default: sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4.sv
// ---------------------------------------------------------------------------
// booth_mul_r4
// Sequential radix-4 (modified) Booth multiplier, two multiplier bits per
// cycle, signed or unsigned operands.
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   start         : accept a new multiply (in IDLE or DONE)
//   signed_mode   : 1 = two's complement operands, 0 = unsigned
//   multiplicand  : operand M (WIDTH bits)
//   multiplier    : operand Q (WIDTH bits)
//   busy          : high while iterating
//   done          : one-cycle pulse, product valid from the same edge
//   product       : 2*WIDTH-bit result, held until the next result lands
// ---------------------------------------------------------------------------
module booth_mul_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int XW    = WIDTH + 2;          // extended operand width
    localparam int AW    = WIDTH + 3;          // accumulator width, holds +/-2M
    localparam int N     = booth_iters(WIDTH);
    localparam int CW    = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [AW-1:0]   acc_r;
    logic [XW-1:0]   q_r;
    logic [XW-1:0]   m_r;
    logic            q_m1_r;
    logic [CW-1:0]   cnt_r;

    sel_t            sel_s;
    logic [XW-1:0]   m_ext_s;
    logic [XW-1:0]   q_ext_s;
    logic [AW-1:0]   m_aw_s;
    logic [AW-1:0]   addend_s;
    logic [AW-1:0]   sum_s;
    logic [AW-1:0]   acc_nx_s;
    logic [XW-1:0]   q_nx_s;
    logic            last_s;
    logic            accept_s;

    booth_r4_recoder u_recoder (
        .window ({q_r[1:0], q_m1_r}),
        .sel    (sel_s)
    );

    // Operand extension: two extra bits make the top recode window see the
    // true sign (signed) or a zero sign (unsigned) of the operand.
    always_comb begin
        m_ext_s = {XW{1'b0}};
        q_ext_s = {XW{1'b0}};
        if (signed_mode) begin
            m_ext_s = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            q_ext_s = {{2{multiplier[WIDTH-1]}}, multiplier};
        end else begin
            m_ext_s = {2'b00, multiplicand};
            q_ext_s = {2'b00, multiplier};
        end
    end

    // Partial product selection and one Booth step (add, then shift by 2)
    always_comb begin
        m_aw_s   = {m_r[XW-1], m_r};
        addend_s = {AW{1'b0}};
        case (sel_s)
            ZERO:    addend_s = {AW{1'b0}};
            PM:      addend_s = m_aw_s;
            P2M:     addend_s = {m_r, 1'b0};
            NM:      addend_s = {AW{1'b0}} - m_aw_s;
            N2M:     addend_s = {AW{1'b0}} - {m_r, 1'b0};
            default: addend_s = {AW{1'b0}};
        endcase
        sum_s    = acc_r + addend_s;
        // Arithmetic shift of {sum, Q, Q-1} right by two places
        acc_nx_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
        q_nx_s   = {sum_s[1:0], q_r[XW-1:2]};
    end

    assign last_s = (cnt_r == CNT_ONE);

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = CALC;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx_s = CALC;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers: load on accept, one Booth step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= {AW{1'b0}};
            q_r    <= {XW{1'b0}};
            m_r    <= {XW{1'b0}};
            q_m1_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (accept_s) begin
            acc_r  <= {AW{1'b0}};
            q_r    <= q_ext_s;
            m_r    <= m_ext_s;
            q_m1_r <= 1'b0;
            cnt_r  <= CNT_LOAD;
        end else if (state_r == CALC) begin
            acc_r  <= acc_nx_s;
            q_r    <= q_nx_s;
            q_m1_r <= q_r[1];
            cnt_r  <= cnt_r - CNT_ONE;
        end else begin
            acc_r  <= acc_r;
            q_r    <= q_r;
            m_r    <= m_r;
            q_m1_r <= q_m1_r;
            cnt_r  <= cnt_r;
        end
    end

    // Registered outputs; product only changes on the edge entering DONE,
    // so it stays stable through a following back-to-back CALC phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= {(2*WIDTH){1'b0}};
        end else begin
            busy <= (state_nx_s == CALC);
            done <= (state_nx_s == DONE);
            if ((state_r == CALC) && last_s) begin
                // After WIDTH+2 retired bits {acc, Q} holds the full product
                product <= {acc_nx_s[WIDTH-3:0], q_nx_s};
            end else begin
                product <= product;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_r4.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_r4
// Self-checking bench for booth_mul_r4 (WIDTH = 16): directed corner cases,
// abort/back-to-back scenarios and random operands against an arithmetic
// reference product.
// ---------------------------------------------------------------------------
module tb_booth_mul_r4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mul_r4 #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiplication, truncated to 32 bits
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic sm);
        longint p;
        if (sm) p = longint'($signed(a)) * longint'($signed(b));
        else    p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // Called at a negedge: present operands with start, return after the sampling edge
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sm);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
        @(posedge clk);
    endtask

    // Cycle numbering: cycle i is the period after edge k+i-1; done expected at i=10
    task automatic wait_done(output logic [31:0] res, output int cyc,
                             output int busy_bad, output int prod_chg);
        logic [31:0] p0;
        cyc = -1; busy_bad = 0; prod_chg = 0; res = 32'd0; p0 = 32'd0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) p0 = product;
            if (done) begin
                cyc = i;
                res = product;
                break;
            end
            if (!busy) busy_bad++;
            if (product !== p0) prod_chg++;
        end
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic sm, input logic [31:0] exp);
        logic [31:0] res;
        int cyc, bb, pc;
        @(negedge clk);
        launch(a, b, sm);
        wait_done(res, cyc, bb, pc);
        chk({tag, "_lat"}, 64'(cyc), 64'd10);
        chk({tag, "_prod"}, 64'(res), 64'(exp));
        chk({tag, "_busy"}, 64'(bb), 64'd0);
        chk({tag, "_hold"}, 64'(pc), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};

    initial begin
        logic [31:0] res, exp;
        logic [15:0] a, b;
        logic        sm;
        int cyc, bb, pc, dones, first;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
        multiplicand = 16'd0; multiplier = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", 64'(product), 64'd0);
        rst = 1'b0;

        run_check("s_neg3x5",   16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
        run_check("s_minxmin",  16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_check("u_onesxones", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run_check("s_onesxones", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

        // Start pulsed mid-operation must be ignored
        @(negedge clk);
        exp = ref_mul(16'h1234, 16'h0056, 1'b0);
        launch(16'h1234, 16'h0056, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        multiplicand = 16'hFFFF; multiplier = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
        dones = 0; first = -1; res = 32'd0;
        for (int i = 5; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) begin
                    first = i;
                    res   = product;
                end
            end
        end
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_lat", 64'(first), 64'd10);
        chk("ign_prod", 64'(res), 64'(exp));
        chk("ign_busy_end", 64'(busy), 64'd0);
        chk("ign_prod_end", 64'(product), 64'(exp));

        // Reset in the middle of an operation
        @(negedge clk);
        launch(16'h00FF, 16'h0F0F, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk("rst_busy_pre", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_no_done", 64'(dones), 64'd0);
        run_check("rst_new", 16'h0123, 16'hFEDC, 1'b1, ref_mul(16'h0123, 16'hFEDC, 1'b1));

        // Back-to-back: start held in the done cycle
        @(negedge clk);
        exp = ref_mul(16'h0011, 16'hFF22, 1'b1);
        launch(16'h0011, 16'hFF22, 1'b1);
        wait_done(res, cyc, bb, pc);
        chk("b2b_first", 64'(res), 64'(exp));
        launch(16'd7, 16'd6, 1'b0);
        wait_done(res, cyc, bb, pc);
        chk("b2b_busy", 64'(bb), 64'd0);
        chk("b2b_hold", 64'(pc), 64'd0);
        chk("b2b_lat", 64'(cyc), 64'd10);
        chk("b2b_prod", 64'(res), 64'h0000_002A);

        // Random operands, with occasional corner values
        for (int n = 0; n < 200; n++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 4)];
            run_check(sm ? "rnd_s" : "rnd_u", a, b, sm, ref_mul(a, b, sm));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
